// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - pipeline-side and SRAM-side signals of the memory stage
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic [31:0]           alu_result;
  logic [31:0]           st_val;
  logic                  ready;
  logic [31:0]           mem_read_data;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [15:0]           sram_dq_out;
  logic [15:0]           sram_dq_in;
  logic                  sram_we_n;
  logic                  sram_oe_n;

  modport master (
    output mem_r_en, mem_w_en, alu_result, st_val, sram_dq_in,
    input  ready, mem_read_data, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
  );

  modport slave (
    input  mem_r_en, mem_w_en, alu_result, st_val, sram_dq_in,
    output ready, mem_read_data, sram_addr, sram_dq_out, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - 32-bit load/store stage over a 16-bit async SRAM, two half-word phases
module mem_stage #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [3:0] LAST   = 4'(WAIT_CYCLES);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  op_write;
  logic [ADDR_WIDTH-2:0] word;
  logic [31:0]           st_data;
  logic [15:0]           rd_low;
  logic [31:0]           read_data;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           dq_out_q;
  logic                  we_n_q;
  logic                  oe_n_q;
  logic                  req;
  logic                  phase_end;
  logic                  unused_addr_bits;

  assign req              = bus.mem_r_en | bus.mem_w_en;
  assign phase_end        = (cnt == LAST);
  assign unused_addr_bits = ^{bus.alu_result[31:ADDR_WIDTH+1], bus.alu_result[1:0]};

  // DONE drives ready high even with a request present: that edge advances the pipeline.
  assign bus.ready         = ((state == S_IDLE) && !req) || (state == S_DONE);
  assign bus.mem_read_data = read_data;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_dq_out   = dq_out_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.sram_oe_n     = oe_n_q;

  // SRAM controls are registered and set up one edge ahead of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_write  <= 1'b0;
      word      <= '0;
      st_data   <= 32'h0;
      rd_low    <= 16'h0;
      read_data <= 32'h0;
      addr_q    <= '0;
      dq_out_q  <= 16'h0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state    <= S_LOW;
            cnt      <= 4'd0;
            op_write <= bus.mem_w_en;
            word     <= bus.alu_result[ADDR_WIDTH:2];
            st_data  <= bus.st_val;
            addr_q   <= {bus.alu_result[ADDR_WIDTH:2], 1'b0};
            we_n_q   <= !bus.mem_w_en;
            oe_n_q   <= bus.mem_w_en;
            dq_out_q <= bus.mem_w_en ? bus.st_val[15:0] : 16'h0;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            state  <= S_HIGH;
            cnt    <= 4'd0;
            addr_q <= {word, 1'b1};
            if (op_write) dq_out_q <= st_data[31:16];
            else          rd_low   <= bus.sram_dq_in;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            state    <= S_DONE;
            cnt      <= 4'd0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            dq_out_q <= 16'h0;
            if (!op_write) read_data <= {bus.sram_dq_in, rd_low};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
`timescale 1ns/1ps
module tb_mem_stage;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel  = 1'b0;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  logic [31:0] a    = 32'h0;
  logic [31:0] d    = 32'h0;

  mem_stage_if #(.ADDR_WIDTH(AW)) if0 ();
  mem_stage_if #(.ADDR_WIDTH(AW)) if1 ();

  mem_stage #(.WAIT_CYCLES(1), .ADDR_WIDTH(AW)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mem_stage #(.WAIT_CYCLES(0), .ADDR_WIDTH(AW)) u1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.mem_r_en   = r_en & !sel;
  assign if0.mem_w_en   = w_en & !sel;
  assign if0.alu_result = a;
  assign if0.st_val     = d;
  assign if1.mem_r_en   = r_en & sel;
  assign if1.mem_w_en   = w_en & sel;
  assign if1.alu_result = a;
  assign if1.st_val     = d;

  logic          m_ready, m_we_n, m_oe_n;
  logic [31:0]   m_rd;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_dq;
  assign m_ready = sel ? if1.ready         : if0.ready;
  assign m_we_n  = sel ? if1.sram_we_n     : if0.sram_we_n;
  assign m_oe_n  = sel ? if1.sram_oe_n     : if0.sram_oe_n;
  assign m_rd    = sel ? if1.mem_read_data : if0.mem_read_data;
  assign m_addr  = sel ? if1.sram_addr     : if0.sram_addr;
  assign m_dq    = sel ? if1.sram_dq_out   : if0.sram_dq_out;

  // Asynchronous SRAM models: write sampled per clock while we_n is low, read combinational.
  logic [15:0]   sram0 [0:(1<<AW)-1];
  logic [15:0]   sram1 [0:(1<<AW)-1];
  int            wr0 = 0, wr1 = 0;
  logic          pw0 = 1'b1, pw1 = 1'b1;
  logic [AW-1:0] pa0 = '0, pa1 = '0;

  assign if0.sram_dq_in = if0.sram_oe_n ? 16'h0 : sram0[if0.sram_addr];
  assign if1.sram_dq_in = if1.sram_oe_n ? 16'h0 : sram1[if1.sram_addr];

  always @(posedge clk) begin
    if (!if0.sram_we_n) begin
      sram0[if0.sram_addr] = if0.sram_dq_out;
      if (pw0 || pa0 != if0.sram_addr) wr0++;
    end
    pw0 = if0.sram_we_n;
    pa0 = if0.sram_addr;
    if (!if1.sram_we_n) begin
      sram1[if1.sram_addr] = if1.sram_dq_out;
      if (pw1 || pa1 != if1.sram_addr) wr1++;
    end
    pw1 = if1.sram_we_n;
    pa1 = if1.sram_addr;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access starting in the next cycle; returns at the negedge of the first ready-high cycle.
  task automatic access(input bit s, input bit r, input bit w, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble,
                        output int stall, output int we_cyc, output int oe_cyc);
    @(posedge clk); #1;
    sel = s; r_en = r; w_en = w; a = addr; d = data;
    stall = 0; we_cyc = 0; oe_cyc = 0;
    @(negedge clk);
    while (!m_ready && stall < 40) begin
      stall++;
      if (!m_we_n) we_cyc++;
      if (!m_oe_n) oe_cyc++;
      @(posedge clk); #1;
      if (scramble) begin
        a = $urandom; d = $urandom; r_en = 1'($urandom); w_en = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n, input bit chk, input logic [31:0] exp_rd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      r_en = 1'b0; w_en = 1'b0;
      @(negedge clk);
      if (chk) begin
        check("idle_ready", 32'(m_ready), 32'd1);
        check("idle_we_n",  32'(m_we_n),  32'd1);
        check("idle_oe_n",  32'(m_oe_n),  32'd1);
        check("idle_rd",    m_rd,         exp_rd);
      end
    end
  endtask

  function automatic int hw_index(input logic [31:0] addr);
    return int'((addr >> 2) & ((32'd1 << (AW - 1)) - 1)) * 2;
  endfunction

  typedef struct {
    bit          s;
    bit          r;
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_stall;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vt [11];
  logic [15:0] ref_mem [int];
  int          pool [8];

  initial begin
    int stall, we_cyc, oe_cyc, wr_before, n, h, k, kind;
    logic [31:0] exp_rd, addr, data;
    bit rr, ww;

    vt[0]  = '{0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 5, 32'h0000_0000};
    vt[1]  = '{0, 1, 0, 32'h0000_0010, 32'h0,        5, 32'hDEAD_BEEF};
    vt[2]  = '{0, 0, 1, 32'h0000_0014, 32'h1234_5678, 5, 32'hDEAD_BEEF};
    vt[3]  = '{0, 0, 1, 32'h0000_0020, 32'h1111_2222, 5, 32'hDEAD_BEEF};
    vt[4]  = '{0, 1, 0, 32'h0000_0020, 32'h0,        5, 32'h1111_2222};
    vt[5]  = '{0, 0, 1, 32'hFFF8_0033, 32'hA5A5_5A5A, 5, 32'h1111_2222};
    vt[6]  = '{0, 1, 0, 32'h0000_0030, 32'h0,        5, 32'hA5A5_5A5A};
    vt[7]  = '{1, 0, 1, 32'h0000_0050, 32'h0102_0304, 3, 32'h0000_0000};
    vt[8]  = '{1, 1, 0, 32'h0000_0052, 32'h0,        3, 32'h0102_0304};
    vt[9]  = '{1, 1, 1, 32'h0000_0050, 32'hCAFE_F00D, 3, 32'h0102_0304};
    vt[10] = '{1, 1, 0, 32'h0000_0050, 32'h0,        3, 32'hCAFE_F00D};

    repeat (2) @(negedge clk);
    check("reset_addr",  32'(if0.sram_addr),   32'd0);
    check("reset_dq",    32'(if0.sram_dq_out), 32'd0);
    rst = 1'b0;
    idle(10, 1'b1, 32'h0);

    for (int i = 0; i < 11; i++) begin
      n = vt[i].s ? 1 : 2;
      wr_before = vt[i].s ? wr1 : wr0;
      access(vt[i].s, vt[i].r, vt[i].w, vt[i].addr, vt[i].data, 1'b0, stall, we_cyc, oe_cyc);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].exp_stall));
      check($sformatf("vec%0d_rd", i), m_rd, vt[i].exp_rd);
      check($sformatf("vec%0d_we_cycles", i), 32'(we_cyc), vt[i].w ? 32'(2 * n) : 32'd0);
      check($sformatf("vec%0d_oe_cycles", i), 32'(oe_cyc), (vt[i].r && !vt[i].w) ? 32'(2 * n) : 32'd0);
      check($sformatf("vec%0d_writes", i), 32'((vt[i].s ? wr1 : wr0) - wr_before), vt[i].w ? 32'd2 : 32'd0);
      if (i == 0) begin
        check("sram_hw8", 32'(sram0[8]), 32'h0000_BEEF);
        check("sram_hw9", 32'(sram0[9]), 32'h0000_DEAD);
      end
    end
    idle(2, 1'b0, 32'h0);

    // Randomized loads/stores on the default instance against a word-level reference.
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(0, (1 << (AW - 1)) - 1));
      addr = 32'(pool[i]) << 2;
      data = $urandom;
      access(1'b0, 1'b0, 1'b1, addr, data, 1'b0, stall, we_cyc, oe_cyc);
      h = hw_index(addr);
      ref_mem[h]     = data[15:0];
      ref_mem[h + 1] = data[31:16];
    end
    exp_rd = if0.mem_read_data === 32'hA5A5_5A5A ? 32'hA5A5_5A5A : 32'hA5A5_5A5A;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      k    = int'($urandom_range(0, 7));
      ww   = (kind != 0);
      rr   = (kind != 1);
      addr = ($urandom & 32'hFFF8_0000) | (32'(pool[k]) << 2) | 32'($urandom_range(0, 3));
      data = $urandom;
      h    = hw_index(addr);
      if (ww) begin
        ref_mem[h]     = data[15:0];
        ref_mem[h + 1] = data[31:16];
      end else begin
        exp_rd = {ref_mem[h + 1], ref_mem[h]};
      end
      access(1'b0, rr, ww, addr, data, 1'b1, stall, we_cyc, oe_cyc);
      check($sformatf("rand%0d_stall", i), 32'(stall), 32'd5);
      check($sformatf("rand%0d_rd", i), m_rd, exp_rd);
      if ($urandom_range(0, 1) == 1) idle(1, 1'b0, 32'h0);
    end

    // Reset during the second LOW cycle of a store.
    access(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_0BAD, 1'b0, stall, we_cyc, oe_cyc);
    @(posedge clk); #1;
    sel = 1'b0; r_en = 1'b0; w_en = 1'b1; a = 32'h0000_0040; d = 32'h7777_8888;
    @(posedge clk);
    @(posedge clk); #2;
    check("midreset_we_before", 32'(m_we_n), 32'd0);
    #1;
    rst = 1'b1; w_en = 1'b0;
    #1;
    check("midreset_ready", 32'(m_ready),       32'd1);
    check("midreset_we_n",  32'(m_we_n),        32'd1);
    check("midreset_oe_n",  32'(m_oe_n),        32'd1);
    check("midreset_addr",  32'(m_addr),        32'd0);
    check("midreset_dq",    32'(m_dq),          32'd0);
    check("midreset_rd",    m_rd,               32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3, 1'b1, 32'h0);
    check("midreset_low_hw",  32'(sram0[32'h20]), 32'h0000_8888);
    check("midreset_high_hw", 32'(sram0[32'h21]), 32'h0000_0BAD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
